// File: rtl/gpc_stream_acc_if.sv
// Beat-in / frame-result-out bundle for gpc_stream_acc: master is the surrounding
// logic (beat source and result sink), slave is the accumulator.
interface gpc_stream_acc_if #(
    parameter int H0     = 5,
    parameter int H1     = 1,
    parameter int H2     = 6,
    parameter int H3     = 1,
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
);
    logic [H0-1:0]     src0;
    logic [H1-1:0]     src1;
    logic [H2-1:0]     src2;
    logic [H3-1:0]     src3;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [BEAT_W-1:0] out_beats;
    logic              out_ovf;

    modport master (
        output src0, src1, src2, src3, in_valid, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_ovf
    );

    modport slave (
        input  src0, src1, src2, src3, in_valid, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_ovf
    );
endinterface

// File: rtl/gpc_stream_acc.sv
// Weighted-popcount (1/2/4/8 column GPC) frame accumulator; GPC_ACC_SAT_EN selects saturate vs wrap.
// Latency: last beat accepted in cycle t -> out_valid high in cycle t+2.
// Backpressure: in_ready drops for FLUSH/OUT; result held stable until out_ready.
module gpc_stream_acc #(
    parameter int H0     = 5,
    parameter int H1     = 1,
    parameter int H2     = 6,
    parameter int H3     = 1,
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    gpc_stream_acc_if.slave   bus
);
    localparam int MAXS = H0 + 2*H1 + 4*H2 + 8*H3;
    localparam int BW   = $clog2(MAXS + 1);
    // Adder is wide enough for both operands plus a carry above ACC_W.
    localparam int SW   = ((BW > ACC_W) ? BW : ACC_W) + 1;

    typedef enum logic [1:0] {ACCUM, FLUSH, OUT} state_t;

    state_t            state;
    logic              in_rdy;
    logic              out_vld;
    logic [ACC_W-1:0]  acc;
    logic [BEAT_W-1:0] beats;
    logic              ovf;
    logic              s1_vld;
    logic [BW-1:0]     s1_sum;
    logic [BW-1:0]     beat_sum;
    logic [SW-1:0]     add_full;
    logic              add_ovf;
    logic              accept;

    assign accept = bus.in_valid & in_rdy;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < H0; i++) beat_sum = beat_sum + BW'(bus.src0[i]);
        for (int i = 0; i < H1; i++) beat_sum = beat_sum + (BW'(bus.src1[i]) << 1);
        for (int i = 0; i < H2; i++) beat_sum = beat_sum + (BW'(bus.src2[i]) << 2);
        for (int i = 0; i < H3; i++) beat_sum = beat_sum + (BW'(bus.src3[i]) << 3);
    end

    assign add_full = SW'(acc) + SW'(s1_sum);
    assign add_ovf  = |add_full[SW-1:ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
            acc     <= '0;
            beats   <= '0;
            ovf     <= 1'b0;
            s1_vld  <= 1'b0;
            s1_sum  <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_sum <= beat_sum;
            end
            if (s1_vld) begin
`ifdef GPC_ACC_SAT_EN
                acc <= add_ovf ? '1 : add_full[ACC_W-1:0];
`else
                acc <= add_full[ACC_W-1:0];
`endif
                if (add_ovf) ovf <= 1'b1;
            end
            if (accept && (beats != '1)) begin
                beats <= beats + BEAT_W'(1);
            end

            case (state)
                ACCUM: begin
                    if (accept && bus.in_last) begin
                        state  <= FLUSH;
                        in_rdy <= 1'b0;
                    end
                end
                // S1 still holds the last beat; it lands in acc this cycle.
                FLUSH: begin
                    state   <= OUT;
                    out_vld <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state   <= ACCUM;
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        acc     <= '0;
                        beats   <= '0;
                        ovf     <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = acc;
    assign bus.out_beats = beats;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_gpc_stream_acc.sv
// Scoreboarded bench: 16-bit accumulator instance for the main frames, 6-bit instance for overflow.
module tb_gpc_stream_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpc_stream_acc_if #(.ACC_W(16)) a ();
    gpc_stream_acc_if #(.ACC_W(6))  b ();

    gpc_stream_acc #(.ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
    gpc_stream_acc #(.ACC_W(6))  dut_b (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        int sum;
        int beats;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result monitors: pop expected frame on every output handshake.
    initial forever begin
        @(negedge clk);
        if (a.out_valid && a.out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out_sum", int'(a.out_sum), e.sum);
                chk("a_out_beats", int'(a.out_beats), e.beats);
                chk("a_out_ovf", int'(a.out_ovf), e.ovf);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (b.out_valid && b.out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_frame", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_sum", int'(b.out_sum), e.sum);
                chk("b_out_beats", int'(b.out_beats), e.beats);
                chk("b_out_ovf", int'(b.out_ovf), e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic beat(input logic [4:0] s0, input logic s1, input logic [5:0] s2,
                        input logic s3, input logic last);
        a.src0     = s0;
        a.src1     = s1;
        a.src2     = s2;
        a.src3     = s3;
        a.in_valid = 1'b1;
        a.in_last  = last;
        @(negedge clk);
        chk("in_ready_on_beat", int'(a.in_ready), 1);
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (a.out_valid && a.out_ready) break;
        end
        chk(nm, int'(n < 40), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_out_valid"}, int'(a.out_valid), 0);
        chk({nm, "_in_ready"}, int'(a.in_ready), 1);
        chk({nm, "_out_sum"}, int'(a.out_sum), 0);
        chk({nm, "_out_beats"}, int'(a.out_beats), 0);
        chk({nm, "_out_ovf"}, int'(a.out_ovf), 0);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        a.src0 = '0; a.src1 = '0; a.src2 = '0; a.src3 = '0;
        a.in_valid = 1'b0; a.in_last = 1'b0; a.out_ready = 1'b1;
        b.src0 = '0; b.src1 = '0; b.src2 = '0; b.src3 = '0;
        b.in_valid = 1'b0; b.in_last = 1'b0; b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_b_out_valid", int'(b.out_valid), 0);
        chk("reset_b_in_ready", int'(b.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single beat 4 + 2*1 + 4*2 = 14, with latency checks.
        e = '{14, 1, 0}; qa.push_back(e);
        beat(5'h0F, 1'b1, 6'h18, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_valid_at_t1", int'(a.out_valid), 0);
        chk("t1_in_ready_flush", int'(a.in_ready), 0);
        @(negedge clk);
        chk("t1_valid_at_t2", int'(a.out_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_valid_after_hs", int'(a.out_valid), 0);
        chk("t1_in_ready_after_hs", int'(a.in_ready), 1);
        @(posedge clk);
        #1;

        // 2+3: three back-to-back beats 14+7+16, result held under backpressure.
        a.out_ready = 1'b0;
        e = '{37, 3, 0}; qa.push_back(e);
        beat(5'h0F, 1'b1, 6'h18, 1'b0, 1'b0);
        beat(5'h19, 1'b0, 6'h04, 1'b0, 1'b0);
        beat(5'h12, 1'b1, 6'h08, 1'b1, 1'b1);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (a.out_valid) break;
        end
        chk("t3_valid_seen", int'(n < 40), 1);
        repeat (5) begin
            chk("t3_hold_valid", int'(a.out_valid), 1);
            chk("t3_hold_sum", int'(a.out_sum), 37);
            chk("t3_hold_beats", int'(a.out_beats), 3);
            chk("t3_hold_ovf", int'(a.out_ovf), 0);
            chk("t3_hold_in_ready", int'(a.in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_valid_after_hs", int'(a.out_valid), 0);
        chk("t3_in_ready_after_hs", int'(a.in_ready), 1);
        @(posedge clk);
        #1;

        // 4: three all-ones beats (39 each = 117) into the 6-bit accumulator.
`ifdef GPC_ACC_SAT_EN
        e = '{63, 3, 1};
`else
        e = '{53, 3, 1};
`endif
        qb.push_back(e);
        for (int i = 0; i < 3; i++) begin
            b.src0 = '1; b.src1 = '1; b.src2 = '1; b.src3 = '1;
            b.in_valid = 1'b1;
            b.in_last  = (i == 2);
            @(posedge clk);
            #1;
        end
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (b.out_valid) break;
        end
        chk("t4_valid_seen", int'(n < 40), 1);
        @(posedge clk);
        #1;

        // 5: reset mid-frame drops the partial frame.
        beat(5'h1F, 1'b1, 6'h3F, 1'b1, 1'b0);
        beat(5'h1F, 1'b1, 6'h3F, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("t5_after_rst");
        @(posedge clk);
        #1;
        e = '{1, 1, 0}; qa.push_back(e);
        beat(5'h01, 1'b0, 6'h00, 1'b0, 1'b1);
        wait_out("t5_frame_done");

        // 6: four single-bit weight-4 beats separated by 3 idle cycles.
        e = '{16, 4, 0}; qa.push_back(e);
        for (int i = 0; i < 4; i++) begin
            beat(5'h00, 1'b0, 6'h01, 1'b0, i == 3);
            if (i < 3) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t6_gap_no_valid", int'(a.out_valid), 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_out("t6_frame_done");

        repeat (3) @(posedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
